// File: rtl/cpu_pkg.sv
// CPU-wide datapath widths and encodings shared by the fetch/decode front end.
package cpu_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/iqueue_if.sv
// Fetch/decode side handshake of the instruction queue.
interface iqueue_if #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic               flush;
  logic               push;
  logic [INSTR_W-1:0] instrIN;
  logic [ADDR_W-1:0]  addrIN;
  logic               pop;
  logic [INSTR_W-1:0] instrOUT;
  logic [ADDR_W-1:0]  addrOUT;
  logic               valid;
  logic               full;
  logic               almost_full;
  logic [CW-1:0]      count;

  modport master (
    output flush, push, instrIN, addrIN, pop,
    input  instrOUT, addrOUT, valid, full, almost_full, count
  );

  modport slave (
    input  flush, push, instrIN, addrIN, pop,
    output instrOUT, addrOUT, valid, full, almost_full, count
  );
endinterface

// File: rtl/iq_mem.sv
// Entry storage for the instruction queue: one synchronous write port,
// one asynchronous read port, deliberately not reset.
module iq_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/iqueue.sv
// Instruction queue between fetch and decode: circular buffer presenting the
// oldest entry first-word-fall-through, with almost-full lookahead and flush.
module iqueue
  import cpu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int INSTR_W   = cpu_pkg::INSTR_W,
  parameter int ADDR_W    = cpu_pkg::ADDR_W,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic   clk,
  input  logic   rst_n,
  iqueue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int W  = INSTR_W + ADDR_W;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid, full;
  logic          push_ok, pop_ok, mem_we;
  logic [W-1:0]  rdata;

  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));

  // A pop frees the slot a same-cycle push reuses, so push is legal when full.
  assign pop_ok  = q.pop & valid;
  assign push_ok = q.push & (~full | pop_ok);
  assign mem_we  = push_ok & ~q.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  iq_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata ({q.instrIN, q.addrIN}),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Storage is unreset; masking keeps outputs deterministic while empty.
  assign q.instrOUT    = valid ? rdata[W-1:ADDR_W] : '0;
  assign q.addrOUT     = valid ? rdata[ADDR_W-1:0] : '0;
  assign q.valid       = valid;
  assign q.full        = full;
  assign q.almost_full = (count_q >= CW'(AFULL_LVL));
  assign q.count       = count_q;
endmodule
